// File: rtl/lfsr_pkg.sv
// Shared constants and pure helper functions for the parametrised Fibonacci LFSR.
// Functions work on a 32-bit container; callers zero-extend and truncate to their width.
package lfsr_pkg;

  localparam int WIDTH_MAX = 32;
  localparam int WIDTH_MIN = 3;

  function automatic logic [WIDTH_MAX-1:0] lfsr_lock(input int width, input bit invert);
    logic [WIDTH_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH_MAX; i++) begin
      if (invert && (i < width)) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Bits of state above the caller's width are zero, so the feedback is unaffected.
  function automatic logic [WIDTH_MAX-1:0] lfsr_shift(input logic [WIDTH_MAX-1:0] state,
                                                      input logic [WIDTH_MAX-1:0] taps,
                                                      input bit invert);
    logic fb;
    fb = (^(state & taps)) ^ invert;
    return {state[WIDTH_MAX-2:0], fb};
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational Fibonacci shift: feedback enters at the LSB, state moves toward the MSB.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int             WIDTH  = 8,
  parameter logic [WIDTH-1:0] TAPS = '0,
  parameter bit             INVERT = 1'b1
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = WIDTH'(lfsr_shift(WIDTH_MAX'(din), WIDTH_MAX'(TAPS), INVERT));

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR generator with seed load, enable, lock-up detect, wrap and period report.
// Optional lock-up recovery is built when LFSR_LOCKUP_RECOVER_EN is defined.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] TAPS        = 8'h88,
  parameter bit               INVERT      = 1'b1,
  parameter int               STEPS       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] out,
  output logic             lockup,
  output logic             out_wrap,
  output logic [WIDTH-1:0] period
);

  localparam logic [WIDTH-1:0] LOCK    = WIDTH'(lfsr_lock(WIDTH, INVERT));
  localparam logic [WIDTH-1:0] RECOVER = LOCK ^ WIDTH'(1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || STEPS < 1 || STEPS > WIDTH) begin : g_bad_cfg
    $error("lfsr_gen: WIDTH or STEPS out of range");
  end

  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] step_cnt;
  logic [WIDTH-1:0] adv;
  logic             do_recover;

  // Chain of single shifts; only the final state of the cycle is ever compared.
  for (genvar i = 0; i < STEPS; i++) begin : g_step
    logic [WIDTH-1:0] s_in;
    logic [WIDTH-1:0] s_out;
    if (i == 0) begin : g_first
      assign s_in = out;
    end else begin : g_next
      assign s_in = g_step[i-1].s_out;
    end
    lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .INVERT(INVERT)
    ) u_step (
      .din (s_in),
      .dout(s_out)
    );
  end

  assign adv    = g_step[STEPS-1].s_out;
  assign lockup = (out == LOCK);

`ifdef LFSR_LOCKUP_RECOVER_EN
  assign do_recover = lockup;
`else
  assign do_recover = 1'b0;
`endif

  // Priority rst > load > en; the recovery reseed restarts the sequence without a wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      out      <= RESET_VALUE;
      start    <= RESET_VALUE;
      step_cnt <= '0;
      period   <= '0;
      out_wrap <= 1'b0;
    end else if (load) begin
      out      <= seed;
      start    <= seed;
      step_cnt <= '0;
      out_wrap <= 1'b0;
    end else if (en) begin
      if (do_recover) begin
        out      <= RECOVER;
        start    <= RECOVER;
        step_cnt <= '0;
        out_wrap <= 1'b0;
      end else if (adv == start) begin
        out      <= adv;
        period   <= step_cnt + WIDTH'(1);
        step_cnt <= '0;
        out_wrap <= 1'b1;
      end else begin
        out      <= adv;
        step_cnt <= step_cnt + WIDTH'(1);
        out_wrap <= 1'b0;
      end
    end else begin
      out_wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboarded bench for lfsr_gen over three configurations (default, STEPS=4, XOR/B8 taps).
module tb_lfsr_gen;

`ifdef LFSR_LOCKUP_RECOVER_EN
  localparam bit RECOVER = 1'b1;
`else
  localparam bit RECOVER = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 0, en_a = 0, load_a = 0;
  logic [7:0] seed_a = 0, out_a, period_a;
  logic       lockup_a, wrap_a;
  logic       rst_b = 0, en_b = 0, load_b = 0;
  logic [7:0] seed_b = 0, out_b, period_b;
  logic       lockup_b, wrap_b;
  logic       rst_c = 0, en_c = 0, load_c = 0;
  logic [7:0] seed_c = 0, out_c, period_c;
  logic       lockup_c, wrap_c;

  lfsr_gen #(.WIDTH(8), .TAPS(8'h88), .INVERT(1'b1), .STEPS(1), .RESET_VALUE(8'h00)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .load(load_a), .seed(seed_a),
    .out(out_a), .lockup(lockup_a), .out_wrap(wrap_a), .period(period_a));
  lfsr_gen #(.WIDTH(8), .TAPS(8'h88), .INVERT(1'b1), .STEPS(4), .RESET_VALUE(8'h00)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .load(load_b), .seed(seed_b),
    .out(out_b), .lockup(lockup_b), .out_wrap(wrap_b), .period(period_b));
  lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .INVERT(1'b0), .STEPS(1), .RESET_VALUE(8'h01)) dut_c (
    .clk(clk), .rst(rst_c), .en(en_c), .load(load_c), .seed(seed_c),
    .out(out_c), .lockup(lockup_c), .out_wrap(wrap_c), .period(period_c));

  typedef struct {
    int         id;
    logic [7:0] out;
    logic       lockup;
    logic       wrap;
    logic [7:0] period;
    string      tag;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  logic [17:0] got;
  int vectors = 0;
  int miscompares = 0;

  logic [7:0] cfg_taps [3] = '{8'h88, 8'h88, 8'hB8};
  bit         cfg_inv  [3] = '{1'b1, 1'b1, 1'b0};
  int         cfg_steps[3] = '{1, 4, 1};
  logic [7:0] cfg_rv   [3] = '{8'h00, 8'h00, 8'h01};

  logic [7:0] m_out[3], m_start[3], m_cnt[3], m_period[3];
  logic       m_wrap[3];

  function automatic logic [7:0] mshift(input logic [7:0] s, input logic [7:0] taps, input bit inv);
    logic fb;
    fb = ^(s & taps);
    if (inv) fb = ~fb;
    return {s[6:0], fb};
  endfunction

  function automatic logic [17:0] obs(input int id);
    case (id)
      0:       return {out_a, lockup_a, wrap_a, period_a};
      1:       return {out_b, lockup_b, wrap_b, period_b};
      default: return {out_c, lockup_c, wrap_c, period_c};
    endcase
  endfunction

  // Drive one cycle of stimulus, advance the reference model, queue its expectation.
  task automatic drive(input int id, input bit r, input bit l, input bit en, input logic [7:0] sd,
                       input string tag);
    logic [7:0] lock, nxt;
    exp_t x;
    case (id)
      0:       begin rst_a = r; load_a = l; en_a = en; seed_a = sd; end
      1:       begin rst_b = r; load_b = l; en_b = en; seed_b = sd; end
      default: begin rst_c = r; load_c = l; en_c = en; seed_c = sd; end
    endcase
    lock = cfg_inv[id] ? 8'hFF : 8'h00;
    if (r) begin
      m_out[id] = cfg_rv[id]; m_start[id] = cfg_rv[id];
      m_cnt[id] = 0; m_period[id] = 0; m_wrap[id] = 0;
    end else if (l) begin
      m_out[id] = sd; m_start[id] = sd; m_cnt[id] = 0; m_wrap[id] = 0;
    end else if (en) begin
      if (RECOVER && m_out[id] == lock) begin
        m_out[id] = lock ^ 8'h01; m_start[id] = m_out[id]; m_cnt[id] = 0; m_wrap[id] = 0;
      end else begin
        nxt = m_out[id];
        for (int k = 0; k < cfg_steps[id]; k++) nxt = mshift(nxt, cfg_taps[id], cfg_inv[id]);
        m_out[id] = nxt;
        if (nxt == m_start[id]) begin
          m_wrap[id] = 1; m_period[id] = m_cnt[id] + 8'd1; m_cnt[id] = 0;
        end else begin
          m_wrap[id] = 0; m_cnt[id] = m_cnt[id] + 8'd1;
        end
      end
    end else begin
      m_wrap[id] = 0;
    end
    x.id = id; x.out = m_out[id]; x.lockup = (m_out[id] == lock);
    x.wrap = m_wrap[id]; x.period = m_period[id]; x.tag = tag;
    sbq.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int id = 0; id < 3; id++) begin
      drive(id, 1, 0, 0, 8'h00, "reset");
      e = sbq.pop_front(); got = obs(e.id); vectors++;
      if (got !== {e.out, e.lockup, e.wrap, e.period}) begin
        miscompares++;
        $display("[TB] FAIL %s[%0d] got %h exp %h", e.tag, id, got, {e.out, e.lockup, e.wrap, e.period});
      end
    end
    vectors++;
    if (out_c !== 8'h01) begin
      miscompares++; $display("[TB] FAIL reset_value got %h exp 01", out_c);
    end
  endtask

  task automatic test_sequence();
    logic [7:0] seq_exp [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E};
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1, 8'h00, "seq");
      e = sbq.pop_front(); got = obs(e.id); vectors++;
      if (got !== {e.out, e.lockup, e.wrap, e.period}) begin
        miscompares++;
        $display("[TB] FAIL seq[%0d] got %h exp %h", i, got, {e.out, e.lockup, e.wrap, e.period});
      end
      vectors++;
      if ({out_a, lockup_a} !== {seq_exp[i], 1'b0}) begin
        miscompares++; $display("[TB] FAIL seq_table[%0d] got %h/%b exp %h/0", i, out_a, lockup_a, seq_exp[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 8'hC3, "hold");
      e = sbq.pop_front(); got = obs(e.id); vectors++;
      if (got !== {e.out, e.lockup, e.wrap, e.period}) begin
        miscompares++;
        $display("[TB] FAIL hold[%0d] got %h exp %h", i, got, {e.out, e.lockup, e.wrap, e.period});
      end
    end
  endtask

  task automatic test_steps();
    logic [7:0] st_exp [2] = '{8'h0F, 8'hF0};
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 1, 8'h00, "steps");
      e = sbq.pop_front(); got = obs(e.id); vectors++;
      if (got !== {e.out, e.lockup, e.wrap, e.period}) begin
        miscompares++;
        $display("[TB] FAIL steps[%0d] got %h exp %h", i, got, {e.out, e.lockup, e.wrap, e.period});
      end
      vectors++;
      if (out_b !== st_exp[i]) begin
        miscompares++; $display("[TB] FAIL steps_table[%0d] got %h exp %h", i, out_b, st_exp[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int first = 0, second = 0;
    for (int i = 1; i <= 520; i++) begin
      drive(2, 0, 0, 1, 8'h00, "wrap");
      e = sbq.pop_front(); got = obs(e.id); vectors++;
      if (got !== {e.out, e.lockup, e.wrap, e.period}) begin
        miscompares++;
        $display("[TB] FAIL wrap[%0d] got %h exp %h", i, got, {e.out, e.lockup, e.wrap, e.period});
      end
      if (wrap_c === 1'b1) begin
        if (first == 0) first = i;
        else if (second == 0) second = i;
      end
    end
    vectors++;
    if (first != 255) begin miscompares++; $display("[TB] FAIL wrap_first got %0d exp 255", first); end
    vectors++;
    if (second != 510) begin miscompares++; $display("[TB] FAIL wrap_second got %0d exp 510", second); end
    vectors++;
    if (period_c !== 8'd255) begin miscompares++; $display("[TB] FAIL wrap_period got %0d exp 255", period_c); end
  endtask

  task automatic test_load();
    drive(0, 0, 1, 1, 8'h5A, "load_en");
    e = sbq.pop_front(); got = obs(e.id); vectors++;
    if (got !== {e.out, e.lockup, e.wrap, e.period}) begin
      miscompares++; $display("[TB] FAIL load_en got %h exp %h", got, {e.out, e.lockup, e.wrap, e.period});
    end
    vectors++;
    if (out_a !== 8'h5A) begin miscompares++; $display("[TB] FAIL load_value got %h exp 5a", out_a); end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, 8'hFF, "load_next");
      e = sbq.pop_front(); got = obs(e.id); vectors++;
      if (got !== {e.out, e.lockup, e.wrap, e.period}) begin
        miscompares++;
        $display("[TB] FAIL load_next[%0d] got %h exp %h", i, got, {e.out, e.lockup, e.wrap, e.period});
      end
    end
  endtask

  task automatic test_lockup();
    drive(2, 0, 1, 0, 8'h00, "lock_load");
    e = sbq.pop_front(); got = obs(e.id); vectors++;
    if (got !== {e.out, e.lockup, e.wrap, e.period}) begin
      miscompares++; $display("[TB] FAIL lock_load got %h exp %h", got, {e.out, e.lockup, e.wrap, e.period});
    end
    vectors++;
    if (lockup_c !== 1'b1) begin miscompares++; $display("[TB] FAIL lock_flag got %b exp 1", lockup_c); end
    for (int i = 0; i < 3; i++) begin
      drive(2, 0, 0, 1, 8'h00, "lock_run");
      e = sbq.pop_front(); got = obs(e.id); vectors++;
      if (got !== {e.out, e.lockup, e.wrap, e.period}) begin
        miscompares++;
        $display("[TB] FAIL lock_run[%0d] got %h exp %h", i, got, {e.out, e.lockup, e.wrap, e.period});
      end
`ifdef LFSR_LOCKUP_RECOVER_EN
      if (i == 0) begin
        vectors++;
        if ({out_c, lockup_c, wrap_c} !== {8'h01, 1'b0, 1'b0}) begin
          miscompares++; $display("[TB] FAIL lock_recover got %h/%b/%b exp 01/0/0", out_c, lockup_c, wrap_c);
        end
      end
`else
      vectors++;
      if ({out_c, wrap_c, period_c} !== {8'h00, 1'b1, 8'd1}) begin
        miscompares++; $display("[TB] FAIL lock_stuck[%0d] got %h/%b/%0d exp 00/1/1", i, out_c, wrap_c, period_c);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    drive(2, 0, 0, 1, 8'h00, "midrun");
    e = sbq.pop_front(); got = obs(e.id); vectors++;
    if (got !== {e.out, e.lockup, e.wrap, e.period}) begin
      miscompares++; $display("[TB] FAIL midrun got %h exp %h", got, {e.out, e.lockup, e.wrap, e.period});
    end
    drive(2, 1, 0, 1, 8'h00, "midreset");
    e = sbq.pop_front(); got = obs(e.id); vectors++;
    if (got !== {e.out, e.lockup, e.wrap, e.period}) begin
      miscompares++; $display("[TB] FAIL midreset got %h exp %h", got, {e.out, e.lockup, e.wrap, e.period});
    end
    vectors++;
    if ({out_c, wrap_c, period_c} !== {8'h01, 1'b0, 8'd0}) begin
      miscompares++; $display("[TB] FAIL midreset_state got %h/%b/%0d exp 01/0/0", out_c, wrap_c, period_c);
    end
    for (int i = 0; i < 3; i++) begin
      drive(2, 0, 0, 1, 8'h00, "after_reset");
      e = sbq.pop_front(); got = obs(e.id); vectors++;
      if (got !== {e.out, e.lockup, e.wrap, e.period}) begin
        miscompares++;
        $display("[TB] FAIL after_reset[%0d] got %h exp %h", i, got, {e.out, e.lockup, e.wrap, e.period});
      end
    end
  endtask

  initial begin
    $display("[TB] lfsr_gen bench start, recovery build = %0b", RECOVER);
    test_reset();
    test_sequence();
    test_steps();
    test_wrap();
    test_load();
    test_lockup();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
